// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction bus (request/response), redirect from execute,
// and the fetch->decode register handshake. The master side is the fetch stage.
interface fetch_stage_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        dataF_valid;
  logic [95:0] dataF;

  modport master (
    output ireq_valid, ireq_addr, dataF_valid, dataF,
    input  iresp_data_ok, iresp_data, redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  ireq_valid, ireq_addr, dataF_valid, dataF,
    output iresp_data_ok, iresp_data, redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch producer: owns the PC, issues ibus requests, feeds the fetch/decode register.
// Optional feature macro FETCH_BUF_EN adds a one-entry skid buffer behind dataF.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);
  typedef enum logic [1:0] {WAIT = 2'd0, REQ = 2'd1, FLUSH = 2'd2} state_t;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instruction;
  } fetch_data_t;

  state_t      state_r, nextState_s;
  logic [63:0] pc_r, pcNext_s;
  logic [63:0] ireqAddr_r, ireqAddrNext_s;
  logic        ireqValid_r;
  logic        dataFValid_r, dataFValidNext_s;
  fetch_data_t dataF_r, dataFNext_s;
  fetch_data_t respData_s;
  logic [63:0] redirTarget_s;
  logic        dataOk_s, resp_s, transfer_s, slotFree_s;
`ifdef FETCH_BUF_EN
  logic        bufValid_r, bufValidNext_s;
  fetch_data_t buf_r, bufNext_s;
`endif

  // Next-state, PC, request address and dataF/buffer moves for the coming cycle.
  always_comb begin
    nextState_s      = state_r;
    pcNext_s         = pc_r;
    ireqAddrNext_s   = ireqAddr_r;
    dataFValidNext_s = dataFValid_r;
    dataFNext_s      = dataF_r;
`ifdef FETCH_BUF_EN
    bufValidNext_s   = bufValid_r;
    bufNext_s        = buf_r;
`endif
    redirTarget_s          = {bus.redirect_pc[63:2], 2'b00};
    dataOk_s               = bus.iresp_data_ok && ireqValid_r;
    transfer_s             = dataFValid_r && !bus.stall;
    resp_s                 = (state_r == REQ) && dataOk_s && !bus.redirect_valid;
    respData_s.pc          = pc_r;
    respData_s.instruction = bus.iresp_data;

    // A redirect kills everything buffered, regardless of stall or returning data.
    if (bus.redirect_valid) begin
      dataFValidNext_s = 1'b0;
`ifdef FETCH_BUF_EN
      bufValidNext_s   = 1'b0;
`endif
    end else begin
`ifdef FETCH_BUF_EN
      if (transfer_s || !dataFValid_r) begin
        if (bufValid_r) begin
          dataFNext_s      = buf_r;
          dataFValidNext_s = 1'b1;
          bufValidNext_s   = resp_s;
          if (resp_s) begin
            bufNext_s = respData_s;
          end else begin
            bufNext_s = buf_r;
          end
        end else if (resp_s) begin
          dataFNext_s      = respData_s;
          dataFValidNext_s = 1'b1;
        end else begin
          dataFValidNext_s = 1'b0;
        end
      end else if (resp_s) begin
        bufNext_s      = respData_s;
        bufValidNext_s = 1'b1;
      end else begin
        bufValidNext_s = bufValid_r;
      end
`else
      if (resp_s) begin
        dataFNext_s      = respData_s;
        dataFValidNext_s = 1'b1;
      end else if (transfer_s) begin
        dataFValidNext_s = 1'b0;
      end else begin
        dataFValidNext_s = dataFValid_r;
      end
`endif
    end

`ifdef FETCH_BUF_EN
    slotFree_s = !bufValidNext_s;
`else
    slotFree_s = !dataFValid_r || !bus.stall;
`endif

    case (state_r)
      WAIT: begin
        if (bus.redirect_valid) begin
          pcNext_s = redirTarget_s;
        end else if (slotFree_s) begin
          nextState_s    = REQ;
          ireqAddrNext_s = pc_r;
        end else begin
          nextState_s = WAIT;
        end
      end
      REQ: begin
        if (bus.redirect_valid) begin
          pcNext_s    = redirTarget_s;
          nextState_s = dataOk_s ? WAIT : FLUSH;
        end else if (dataOk_s) begin
          pcNext_s = pc_r + PC_STEP;
`ifdef FETCH_BUF_EN
          if (slotFree_s) begin
            nextState_s    = REQ;
            ireqAddrNext_s = pc_r + PC_STEP;
          end else begin
            nextState_s = WAIT;
          end
`else
          nextState_s = WAIT;
`endif
        end else begin
          nextState_s = REQ;
        end
      end
      FLUSH: begin
        if (bus.redirect_valid) begin
          pcNext_s = redirTarget_s;
        end else begin
          pcNext_s = pc_r;
        end
        nextState_s = dataOk_s ? WAIT : FLUSH;
      end
      default: begin
        nextState_s = WAIT;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= WAIT;
      pc_r         <= RESET_PC;
      ireqAddr_r   <= RESET_PC;
      ireqValid_r  <= 1'b0;
      dataFValid_r <= 1'b0;
      dataF_r      <= {RESET_PC, 32'h0000_0000};
`ifdef FETCH_BUF_EN
      bufValid_r   <= 1'b0;
      buf_r        <= {RESET_PC, 32'h0000_0000};
`endif
    end else begin
      state_r      <= nextState_s;
      pc_r         <= pcNext_s;
      ireqAddr_r   <= ireqAddrNext_s;
      ireqValid_r  <= (nextState_s != WAIT);
      dataFValid_r <= dataFValidNext_s;
      dataF_r      <= dataFNext_s;
`ifdef FETCH_BUF_EN
      bufValid_r   <= bufValidNext_s;
      buf_r        <= bufNext_s;
`endif
    end
  end

  assign bus.ireq_valid  = ireqValid_r;
  assign bus.ireq_addr   = ireqAddr_r;
  assign bus.dataF_valid = dataFValid_r;
  assign bus.dataF       = dataF_r;
endmodule
